// File: rtl/noc_pkg.sv
// Shared mesh-router definitions: flit type codes, output-port indices,
// the input-stage state enum and the XY route function.
package noc_pkg;

   localparam logic [1:0] FT_HEAD   = 2'b10;
   localparam logic [1:0] FT_BODY   = 2'b00;
   localparam logic [1:0] FT_TAIL   = 2'b01;
   localparam logic [1:0] FT_SINGLE = 2'b11;

   localparam int P_LOCAL = 0;
   localparam int P_NORTH = 1;
   localparam int P_EAST  = 2;
   localparam int P_SOUTH = 3;
   localparam int P_WEST  = 4;

   typedef enum logic {
      ST_IDLE,
      ST_ACTIVE
   } state_t;

   // Dimension-ordered routing: resolve X completely before moving in Y.
   function automatic logic [4:0] xy_route(input logic [1:0] dest_x,
                                           input logic [1:0] dest_y,
                                           input logic [1:0] cur_x,
                                           input logic [1:0] cur_y);
      logic [4:0] r;
      r = '0;
      if (dest_x > cur_x)      r[P_EAST]  = 1'b1;
      else if (dest_x < cur_x) r[P_WEST]  = 1'b1;
      else if (dest_y > cur_y) r[P_NORTH] = 1'b1;
      else if (dest_y < cur_y) r[P_SOUTH] = 1'b1;
      else                     r[P_LOCAL] = 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/input_flit_buffer_if.sv
// Flit/write-enable channel from the upstream mux plus the request/grant
// handshake toward the switch allocator.
interface input_flit_buffer_if #(parameter int FLIT_W = 8);
   logic [FLIT_W-1:0] in_flit;
   logic              in_wr_en;
   logic              full;
   logic [FLIT_W-1:0] out_flit;
   logic              out_valid;
   logic [4:0]        req;
   logic              grant;
   logic              drop_err;

   modport master (output in_flit, in_wr_en, grant,
                   input  full, out_flit, out_valid, req, drop_err);

   modport slave  (input  in_flit, in_wr_en, grant,
                   output full, out_flit, out_valid, req, drop_err);
endinterface

// File: rtl/input_flit_buffer_fifo.sv
// Circular-buffer flit FIFO; writes when full and reads when empty are ignored.
module flit_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [W-1:0]             wr_data,
   input  logic                     rd_en,
   output logic [W-1:0]             rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  mem_d [DEPTH];
   logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_wr, do_rd;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rd_data = mem_q[rd_ptr_q];

   // Pointers wrap for free because DEPTH is a power of two.
   always_comb begin
      do_wr    = wr_en && !full;
      do_rd    = rd_en && !empty;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q + AW'(do_wr);
      rd_ptr_d = rd_ptr_q + AW'(do_rd);
      count_d  = count_q + CW'(do_wr) - CW'(do_rd);
      if (do_wr) mem_d[wr_ptr_q] = wr_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q    <= '{default: '0};
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/input_flit_buffer.sv
// Router input port: buffers incoming flits, routes head flits XY and holds
// the one-hot output request from head to tail (wormhole switching).
module input_flit_buffer
   import noc_pkg::*;
#(
   parameter int         FLIT_W = 8,
   parameter int         DEPTH  = 4,
   parameter logic [1:0] CUR_X  = 2'd0,
   parameter logic [1:0] CUR_Y  = 2'd0
) (
   input logic                clk,
   input logic                rst,
   input_flit_buffer_if.slave bus
);
   logic [FLIT_W-1:0]       fifo_rd_data;
   logic                    fifo_full, fifo_empty;
   logic [$clog2(DEPTH):0]  fifo_count;
   logic                    pop, discard, out_valid;
   logic [1:0]              front_type;
   state_t                  state_q, state_d;
   logic [4:0]              req_q, req_d;
   logic                    drop_err_q, drop_err_d;

   flit_fifo #(.W(FLIT_W), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (bus.in_wr_en),
      .wr_data (bus.in_flit),
      .rd_en   (pop),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   assign front_type    = fifo_rd_data[7:6];
   assign out_valid     = (state_q == ST_ACTIVE) && (fifo_count != '0);
   assign bus.out_valid = out_valid;
   assign bus.out_flit  = fifo_rd_data;
   assign bus.full      = fifo_full;
   assign bus.req       = req_q;
   assign bus.drop_err  = drop_err_q;

   // In IDLE the front flit must open a packet; anything else is a stray
   // remnant and is discarded. In ACTIVE the request is held until the tail leaves.
   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      pop     = 1'b0;
      discard = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               if (front_type == FT_HEAD || front_type == FT_SINGLE) begin
                  req_d   = xy_route(fifo_rd_data[5:4], fifo_rd_data[3:2], CUR_X, CUR_Y);
                  state_d = ST_ACTIVE;
               end else begin
                  pop     = 1'b1;
                  discard = 1'b1;
               end
            end
         end
         ST_ACTIVE: begin
            if (bus.grant && out_valid) begin
               pop = 1'b1;
               if (front_type == FT_TAIL || front_type == FT_SINGLE) begin
                  state_d = ST_IDLE;
                  req_d   = '0;
               end
            end
         end
      endcase
      drop_err_d = discard;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         req_q      <= '0;
         drop_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         req_q      <= req_d;
         drop_err_q <= drop_err_d;
      end
   end

endmodule
